// File: rtl/wb_config_shifter.sv
// wb_config_shifter: Wishbone-fed engine that serialises buffered config words LSB-first
// onto the masked column chains and then pulses set on the same columns.
module wb_config_shifter #(
   parameter int          NUM_COLS   = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter int          SET_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_addr_i,
   input  logic [31:0]         wbs_data_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_data_o,
   output logic [NUM_COLS-1:0] cen_out,
   output logic [NUM_COLS-1:0] shift_out,
   output logic [NUM_COLS-1:0] set_out,
   output logic                busy_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = SET_CYCLES > 1 ? $clog2(SET_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, SET} state_t;
   state_t              state, state_n;
   logic [NUM_COLS-1:0] mask, mask_n;
   logic [31:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count, count_n;
   logic [31:0]         sreg, sreg_n, status, rdata_n;
   logic [4:0]          bit_cnt, bit_cnt_n;
   logic [SW-1:0]       set_cnt, set_cnt_n;
   logic [15:0]         words;
   logic                pending, pending_n;
   logic                full, empty, full_wr, stall, accept, push, pop, word_done, enter_set;
   logic [1:0]          reg_idx;
   logic                unused_addr;

   assign reg_idx     = wbs_addr_i[3:2];
   assign unused_addr = ^wbs_addr_i[1:0];
   assign full        = count == (AW+1)'(FIFO_DEPTH);
   assign empty       = count == '0;
   assign full_wr     = wbs_we_i && wbs_sel_i == 4'hF;
   // MASK waits for the engine to go idle, DATA waits for FIFO room; nothing else stalls
   assign stall       = full_wr && ((reg_idx == 2'd0 && busy_out) || (reg_idx == 2'd1 && full));
   assign accept      = wbs_stb_i && wbs_cyc_i && !wbs_ack_o &&
                        wbs_addr_i[31:4] == BASE_ADDR[31:4] && !stall;
   assign push        = accept && full_wr && reg_idx == 2'd1;
   assign mask_n      = (accept && full_wr && reg_idx == 2'd0) ? wbs_data_i[NUM_COLS-1:0] : mask;
   assign enter_set   = state == IDLE && empty && pending;
   // a COMMIT landing on the SET entry edge re-arms rather than being swallowed
   assign pending_n   = (accept && full_wr && reg_idx == 2'd2) || (pending && !enter_set);
   assign count_n     = count + (AW+1)'(push) - (AW+1)'(pop);
   assign status      = {words, 8'd0, 4'(count), 1'b0, empty, full, busy_out};
   assign rdata_n     = (accept && !wbs_we_i) ?
                        (reg_idx == 2'd0 ? 32'(mask) : reg_idx == 2'd3 ? status : 32'd0) : 32'd0;

   always_comb begin
      state_n   = state;
      sreg_n    = sreg;
      bit_cnt_n = bit_cnt;
      set_cnt_n = set_cnt;
      pop       = 1'b0;
      word_done = 1'b0;
      if (state == IDLE) begin
         if (!empty) begin
            pop       = 1'b1;
            sreg_n    = mem[rd_ptr];
            bit_cnt_n = '0;
            state_n   = SHIFT;
         end else if (pending) begin
            set_cnt_n = '0;
            state_n   = SET;
         end
      end else if (state == SHIFT) begin
         sreg_n    = sreg >> 1;
         bit_cnt_n = bit_cnt + 5'd1;
         if (bit_cnt == 5'd31) begin
            word_done = 1'b1;
            if (!empty) begin
               pop    = 1'b1;
               sreg_n = mem[rd_ptr];
            end else begin
               state_n = IDLE;
            end
         end
      end else begin
         set_cnt_n = set_cnt + SW'(1);
         if (set_cnt == SW'(SET_CYCLES - 1)) state_n = IDLE;
      end
   end

   // outputs are registered from next-state values so they line up with the state they describe
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         mask       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         sreg       <= '0;
         bit_cnt    <= '0;
         set_cnt    <= '0;
         words      <= '0;
         pending    <= 1'b0;
         cen_out    <= '0;
         shift_out  <= '0;
         set_out    <= '0;
         busy_out   <= 1'b0;
         wbs_ack_o  <= 1'b0;
         wbs_data_o <= '0;
      end else begin
         state      <= state_n;
         mask       <= mask_n;
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         count      <= count_n;
         sreg       <= sreg_n;
         bit_cnt    <= bit_cnt_n;
         set_cnt    <= set_cnt_n;
         words      <= words + 16'(word_done);
         pending    <= pending_n;
         cen_out    <= state_n == SHIFT ? mask_n : '0;
         shift_out  <= state_n == SHIFT ? mask_n & {NUM_COLS{sreg_n[0]}} : '0;
         set_out    <= state_n == SET ? mask_n : '0;
         busy_out   <= state_n != IDLE || count_n != '0 || pending_n;
         wbs_ack_o  <= accept;
         wbs_data_o <= rdata_n;
      end
   end

   always_ff @(posedge wb_clk_i)
      if (push) mem[wr_ptr] <= wbs_data_i;
endmodule

// File: tb/tb_wb_config_shifter.sv
// tb_wb_config_shifter: directed sequence with random data; expected bit streams and set
// pulses come from a per-cycle queue model built from written words and masks.
module tb_wb_config_shifter;
   localparam int NC = 8;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic          wb_clk_i = 1'b0, wb_rst_i = 1'b1;
   logic          wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
   logic [3:0]    wbs_sel_i = 4'h0;
   logic [31:0]   wbs_addr_i = '0, wbs_data_i = '0;
   logic          wbs_ack_o, busy_out;
   logic [31:0]   wbs_data_o;
   logic [NC-1:0] cen_out, shift_out, set_out;

   int checks = 0, passed = 0, cycle = 0, words_m = 0;
   typedef struct packed {int cyc; logic [NC-1:0] cen; logic [NC-1:0] sh;} ev_t;
   typedef struct packed {logic [NC-1:0] cen; logic [NC-1:0] sh;} exp_t;
   ev_t           obs_q[$];
   exp_t          exp_q[$];
   int            set_q[$], exp_set[$];
   logic [NC-1:0] setv_q[$];

   wb_config_shifter #(.NUM_COLS(NC), .FIFO_DEPTH(4), .SET_CYCLES(2), .BASE_ADDR(BASE)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
      .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_addr_i(wbs_addr_i), .wbs_data_i(wbs_data_i),
      .wbs_ack_o(wbs_ack_o), .wbs_data_o(wbs_data_o), .cen_out(cen_out), .shift_out(shift_out),
      .set_out(set_out), .busy_out(busy_out));

   always #5 wb_clk_i = ~wb_clk_i;
   always @(posedge wb_clk_i) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge wb_clk_i) begin
      if (cen_out != '0 || shift_out != '0) obs_q.push_back(ev_t'{cycle, cen_out, shift_out});
      if (set_out != '0) begin
         set_q.push_back(cycle);
         setv_q.push_back(set_out);
      end
      if (!wbs_ack_o) check("rdata idle", 64'(wbs_data_o), 64'd0);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge wb_clk_i);
      #1;
   endtask

   task automatic wb(input logic [31:0] addr, input logic we, input logic [31:0] d, input logic [3:0] sel,
                     input int budget, output logic [31:0] rd, output int rq, output int ak);
      wbs_addr_i = addr; wbs_we_i = we; wbs_data_i = d; wbs_sel_i = sel;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      rq = cycle; ak = -1; rd = '0;
      for (int i = 0; i < budget && ak < 0; i++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            ak = cycle;
            rd = wbs_data_o;
         end
      end
      tick(1);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [1:0] r, input logic [31:0] d, output int rq, output int ak);
      logic [31:0] rd;
      wb(BASE | (32'(r) << 2), 1'b1, d, 4'hF, 3000, rd, rq, ak);
      check({tag, " ack"}, 64'(ak >= 0), 64'd1);
   endtask

   task automatic rd_reg(input string tag, input logic [1:0] r, output logic [31:0] rd);
      int rq, ak;
      wb(BASE | (32'(r) << 2), 1'b0, 32'd0, 4'hF, 50, rd, rq, ak);
      check({tag, " ack"}, 64'(ak == rq + 1), 64'd1);
   endtask

   function automatic void push_word(input logic [NC-1:0] m, input logic [31:0] w);
      for (int i = 0; i < 32; i++)
         if (m != '0) exp_q.push_back(exp_t'{m, m & {NC{w[i]}}});
   endfunction

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_out !== 1'b0 && n < 3000) begin
         tick(1);
         n++;
      end
      check({tag, " idle"}, 64'(n < 3000), 64'd1);
   endtask

   task automatic compare_stream(input string tag, input int first);
      check({tag, " len"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check({tag, " bit"}, {16'd0, 32'(obs_q[i].cyc), obs_q[i].cen, obs_q[i].sh},
               {16'd0, 32'(first + i), exp_q[i].cen, exp_q[i].sh});
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic compare_sets(input string tag, input logic [NC-1:0] m);
      check({tag, " set len"}, 64'(set_q.size()), 64'(exp_set.size()));
      for (int i = 0; i < set_q.size() && i < exp_set.size(); i++)
         check({tag, " set"}, {24'd0, 32'(set_q[i]), setv_q[i]}, {24'd0, 32'(exp_set[i]), m});
      set_q.delete();
      setv_q.delete();
      exp_set.delete();
   endtask

   initial begin
      logic [31:0]   rd, w;
      logic [NC-1:0] m;
      int            rq, ak, rq2, ak2, first, c;
      tick(3);
      wb_rst_i = 1'b0;
      check("reset outs", 64'({cen_out, shift_out, set_out, busy_out, wbs_ack_o}), 64'd0);
      rd_reg("status rst", 2'd3, rd);
      check("status rst", 64'(rd), 64'h4);
      rd_reg("mask rst", 2'd0, rd);
      check("mask rst", 64'(rd), 64'h0);

      m = 8'h04;
      wr("mask", 2'd0, 32'(m), rq, ak);
      w = 32'hA5A5_0001;
      wr("data", 2'd1, w, rq, ak);
      check("data ack latency", 64'(ak), 64'(rq + 1));
      push_word(m, w);
      first = ak + 1;
      wait_idle("single");
      compare_stream("single", first);
      words_m++;

      for (int k = 0; k < 3; k++) begin
         m = 8'($urandom_range(1, 255));
         wr("rand mask", 2'd0, 32'(m), rq, ak);
         w = $urandom;
         wr("rand data", 2'd1, w, rq, ak);
         push_word(m, w);
         first = ak + 1;
         wait_idle("rand");
         compare_stream("rand word", first);
         words_m++;
      end

      m = 8'hFF;
      wr("mask", 2'd0, 32'(m), rq, ak);
      for (int k = 0; k < 6; k++) begin
         w = $urandom;
         wr("burst data", 2'd1, w, rq, ak);
         push_word(m, w);
         if (k == 0) first = ak + 1;
      end
      check("sixth data stall", 64'(ak), 64'(first + 33));
      wr("commit", 2'd2, $urandom, rq, ak);
      wait_idle("burst");
      exp_set.push_back(first + 193);
      exp_set.push_back(first + 194);
      compare_stream("burst", first);
      compare_sets("burst", m);
      words_m += 6;
      rd_reg("status words", 2'd3, rd);
      check("status words", 64'(rd), 64'({16'(words_m), 16'h0004}));

      wbs_addr_i = BASE | 32'hC; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      @(negedge wb_clk_i) check("held ack c0", 64'(wbs_ack_o), 64'd0);
      @(negedge wb_clk_i) check("held ack c1", 64'(wbs_ack_o), 64'd1);
      check("held rdata", 64'(wbs_data_o), 64'({16'(words_m), 16'h0004}));
      @(negedge wb_clk_i) check("held ack c2", 64'(wbs_ack_o), 64'd0);
      @(negedge wb_clk_i) check("held ack c3", 64'(wbs_ack_o), 64'd1);
      tick(1);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;

      wb(BASE | 32'h4, 1'b1, $urandom, 4'h3, 50, rd, rq, ak);
      check("sel3 ack latency", 64'(ak), 64'(rq + 1));
      wb((BASE | 32'h4) ^ (32'd1 << $urandom_range(4, 31)), 1'b1, $urandom, 4'hF, 20, rd, rq, ak);
      check("out of range no ack", 64'(ak < 0), 64'd1);
      tick(40);
      check("no side effect busy", 64'(busy_out), 64'd0);
      compare_stream("no side effect", 0);

      m = 8'h0F;
      wr("mask", 2'd0, 32'(m), rq, ak);
      w = $urandom;
      wr("data", 2'd1, w, rq, ak);
      push_word(m, w);
      first = ak + 1;
      tick(5);
      wr("mask stall", 2'd0, 32'hF0, rq, ak);
      check("mask stall ack", 64'(ak), 64'(first + 33));
      wait_idle("mask stall");
      compare_stream("old mask", first);
      words_m++;
      m = 8'hF0;
      rd_reg("mask rb", 2'd0, rd);
      check("mask rb", 64'(rd), 64'hF0);

      wr("commit1", 2'd2, 32'd0, rq, ak);
      c = rq;
      wr("commit2", 2'd2, 32'd0, rq2, ak2);
      check("commit2 ack latency", 64'(ak2), 64'(rq2 + 1));
      exp_set.push_back(c + 2);
      exp_set.push_back(c + 3);
      exp_set.push_back(c + 5);
      exp_set.push_back(c + 6);
      wait_idle("double commit");
      compare_stream("double commit", 0);
      compare_sets("double commit", m);

      m = 8'($urandom_range(1, 255));
      wr("mask", 2'd0, 32'(m), rq, ak);
      wr("data", 2'd1, $urandom, rq, ak);
      tick(10);
      #2 wb_rst_i = 1'b1;
      #1 check("async reset outs", 64'({cen_out, shift_out, set_out, busy_out, wbs_ack_o, wbs_data_o}), 64'd0);
      tick(2);
      wb_rst_i = 1'b0;
      obs_q.delete();
      exp_q.delete();
      words_m = 0;
      rd_reg("status after rst", 2'd3, rd);
      check("status after rst", 64'(rd), 64'h4);
      rd_reg("mask after rst", 2'd0, rd);
      check("mask after rst", 64'(rd), 64'h0);

      m = 8'($urandom_range(1, 255));
      wr("mask", 2'd0, 32'(m), rq, ak);
      w = $urandom;
      wr("data", 2'd1, w, rq, ak);
      push_word(m, w);
      first = ak + 1;
      wait_idle("post reset");
      compare_stream("post reset", first);
      words_m++;
      rd_reg("final status", 2'd3, rd);
      check("final status", 64'(rd), 64'({16'(words_m), 16'h0004}));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
